// File: rtl/crtc_pkg.sv
// crtc_pkg: CRTC register indices, bus addresses and vertical sequencer states
package crtc_pkg;
  localparam int REG_R0 = 0, REG_R1 = 1, REG_R2 = 2, REG_R3 = 3, REG_R4 = 4, REG_R5 = 5;
  localparam int REG_R6 = 6, REG_R7 = 7, REG_R8 = 8, REG_R9 = 9, REG_R10 = 10, REG_R11 = 11;
  localparam int REG_R12 = 12, REG_R13 = 13, REG_R14 = 14, REG_R15 = 15, REG_R16 = 16, REG_R17 = 17;
  localparam logic [15:0] CPU_ADDR_SEL = 16'hE880;
  localparam logic [15:0] CPU_ADDR_DATA = 16'hE881;
  localparam logic [15:0] PI_READ_BASE = 16'hE8F0;
  typedef enum logic [1:0] {ROWS, ADJUST, FRAME_END} vstate_t;
endpackage

// File: rtl/crtc_sync_gen.sv
// crtc_sync_gen: sync pulse from a start compare and a width down-counter where width 0 means 16
module crtc_sync_gen (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       start,
  input  logic       tick,
  input  logic [3:0] width,
  output logic       active
);
  logic [4:0] rem;
  assign active = start || rem != 5'd0;
  always_ff @(posedge clk)
    if (rst) rem <= '0;
    else if (en) rem <= (start ? {width == 4'd0, width} : rem) - {4'd0, tick && active};
endmodule

// File: rtl/crtc_timing.sv
// crtc_timing: CRTC raster sequencer producing sync, display enable and video addresses
module crtc_timing
  import crtc_pkg::*;
#(
  parameter int MA_WIDTH = 14,
  parameter int RA_WIDTH = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                char_en,
  input  logic [7:0]          r0_h_total,
  input  logic [7:0]          r1_h_displayed,
  input  logic [7:0]          r2_h_sync_pos,
  input  logic [7:0]          r3_sync_width,
  input  logic [6:0]          r4_v_total,
  input  logic [RA_WIDTH-1:0] r5_v_adjust,
  input  logic [6:0]          r6_v_displayed,
  input  logic [6:0]          r7_v_sync_pos,
  input  logic [RA_WIDTH-1:0] r9_max_scan,
  input  logic [13:0]         r12_r13_start,
  output logic                h_sync,
  output logic                v_sync,
  output logic                de,
  output logic [MA_WIDTH-1:0] ma,
  output logic [RA_WIDTH-1:0] ra,
  output logic                frame_start
);
  logic [7:0] h_count;
  logic [6:0] row;
  logic [RA_WIDTH-1:0] ra_count, adj_count;
  logic [MA_WIDTH-1:0] ma_row, base;
  vstate_t state;
  logic first, fs, in_adj, line_end, row_end, h_active, hs_now, vs_now;
  assign fs = first || state == FRAME_END;
  assign in_adj = !fs && state == ADJUST;
  assign base = fs ? MA_WIDTH'(r12_r13_start) : ma_row;
  assign line_end = h_count == r0_h_total;
  assign row_end = ra_count == r9_max_scan;
  assign h_active = h_count < r1_h_displayed;
  crtc_sync_gen h_gen (
    .clk, .rst(reset), .en(char_en), .start(h_count == r2_h_sync_pos), .tick(1'b1),
    .width(r3_sync_width[3:0]), .active(hs_now)
  );
  crtc_sync_gen v_gen (
    .clk, .rst(reset), .en(char_en),
    .start(!in_adj && row == r7_v_sync_pos && ra_count == '0 && h_count == '0),
    .tick(line_end), .width(r3_sync_width[7:4]), .active(vs_now)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      h_count <= '0;
      row <= '0;
      ra_count <= '0;
      adj_count <= '0;
      ma_row <= '0;
      state <= ROWS;
      first <= 1'b1;
      h_sync <= 1'b0;
      v_sync <= 1'b0;
      de <= 1'b0;
      ma <= '0;
      ra <= '0;
      frame_start <= 1'b0;
    end else if (char_en) begin
      h_sync <= hs_now;
      v_sync <= vs_now;
      de <= h_active && row < r6_v_displayed && !in_adj;
      ma <= h_active ? base + MA_WIDTH'(h_count) : ma;
      ra <= ra_count;
      frame_start <= fs;
      first <= 1'b0;
      h_count <= line_end ? 8'd0 : h_count + 8'd1;
      ma_row <= base + ((line_end && row_end && !in_adj) ? MA_WIDTH'(r1_h_displayed) : '0);
      if (fs) state <= ROWS;
      if (line_end && !in_adj) begin
        ra_count <= row_end ? '0 : ra_count + RA_WIDTH'(1);
        if (row_end) row <= row == r4_v_total ? 7'd0 : row + 7'd1;
        if (row_end && row == r4_v_total) state <= r5_v_adjust != '0 ? ADJUST : FRAME_END;
      end else if (line_end) begin
        ra_count <= ra_count + RA_WIDTH'(1);
        adj_count <= adj_count + RA_WIDTH'(1);
        if (adj_count == r5_v_adjust - RA_WIDTH'(1)) begin
          state <= FRAME_END;
          ra_count <= '0;
          adj_count <= '0;
        end
      end
    end
  end
endmodule
